// File: rtl/ldpc_fp_pkg.sv
// Shared FP32 definitions for the LDPC soft-decision datapath:
// field widths, special encodings and the message-extractor FSM states.
package ldpc_fp_pkg;

  localparam int unsigned FP_SIGN_W = 1;
  localparam int unsigned FP_EXP_W  = 8;
  localparam int unsigned FP_MAN_W  = 23;
  localparam int unsigned FP_BIAS   = 127;

  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_POS_INF  = 32'h7F80_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_S1,
    ST_S2,
    ST_S3,
    ST_FIN
  } state_t;

endpackage

// File: rtl/fp32_subtractor.sv
// Combinational IEEE-754 single subtractor y = a - b, truncating, with
// denormal inputs/results flushed to zero and overflow saturating to infinity.
module fp32_subtractor
  import ldpc_fp_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  logic              sa, sb, sl, ss;
  logic [7:0]        ea, eb, el, es;
  logic [23:0]       ma, mb, ml, ms;
  logic [7:0]        shamt;
  logic [26:0]       big_ext, small_ext, aligned;
  logic              sticky;
  logic [27:0]       res, norm;
  logic [4:0]        lz;
  logic signed [9:0] exp_r;

  always_comb begin
    sa = a[31];
    ea = a[30:FP_MAN_W];
    ma = (ea == '0) ? '0 : {1'b1, a[FP_MAN_W-1:0]};
    // a - b is computed as a + (-b)
    sb = ~b[31];
    eb = b[30:FP_MAN_W];
    mb = (eb == '0) ? '0 : {1'b1, b[FP_MAN_W-1:0]};

    if ({ea, ma} >= {eb, mb}) begin
      sl = sa; el = ea; ml = ma;
      ss = sb; es = eb; ms = mb;
    end else begin
      sl = sb; el = eb; ml = mb;
      ss = sa; es = ea; ms = ma;
    end

    // Three extra low bits; anything shifted further out folds into a sticky
    // LSB so that a truncated difference never exceeds the exact magnitude.
    shamt     = el - es;
    big_ext   = {ml, 3'b000};
    small_ext = {ms, 3'b000};
    if (shamt >= 8'd27) begin
      aligned = '0;
      sticky  = |small_ext;
    end else begin
      aligned = small_ext >> shamt;
      sticky  = |(small_ext & ~({27{1'b1}} << shamt));
    end
    aligned[0] = aligned[0] | sticky;

    if (sl == ss) res = {1'b0, big_ext} + {1'b0, aligned};
    else          res = {1'b0, big_ext} - {1'b0, aligned};

    lz = '0;
    for (int unsigned i = 0; i < 28; i++) begin
      if (res[i]) lz = 5'(27 - i);
    end
    norm  = res << lz;
    exp_r = $signed({2'b00, el}) + 10'sd1 - $signed({5'b00000, lz});

    if (res == '0)              y = FP_POS_ZERO;
    else if (exp_r <= 10'sd0)   y = {sl, 31'b0};
    else if (exp_r >= 10'sd255) y = {sl, FP_POS_INF[30:0]};
    else                        y = {sl, exp_r[7:0], norm[26:4]};
  end

endmodule

// File: rtl/column_message_extractor.sv
// Derives the three variable-to-check messages qi = sum - ri of one column,
// one per cycle through a single shared FP32 subtractor.
module column_message_extractor
  import ldpc_fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] sum,
  input  logic [31:0] r1,
  input  logic [31:0] r2,
  input  logic [31:0] r3,
  output logic [31:0] q1,
  output logic [31:0] q2,
  output logic [31:0] q3,
  output logic        busy,
  output logic        done
);

  state_t      state;
  logic [31:0] lsum, lr1, lr2, lr3;
  logic [31:0] sub_b, diff;

  always_comb begin
    sub_b = '0;
    case (state)
      ST_S1:   sub_b = lr1;
      ST_S2:   sub_b = lr2;
      ST_S3:   sub_b = lr3;
      default: sub_b = '0;
    endcase
  end

  fp32_subtractor u_sub (
    .a (lsum),
    .b (sub_b),
    .y (diff)
  );

  // busy/done are registered alongside the state so they track it exactly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      lsum  <= FP_POS_ZERO;
      lr1   <= FP_POS_ZERO;
      lr2   <= FP_POS_ZERO;
      lr3   <= FP_POS_ZERO;
      q1    <= FP_POS_ZERO;
      q2    <= FP_POS_ZERO;
      q3    <= FP_POS_ZERO;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            lsum  <= sum;
            lr1   <= r1;
            lr2   <= r2;
            lr3   <= r3;
            busy  <= 1'b1;
            state <= ST_S1;
          end
        end
        ST_S1: begin
          q1    <= diff;
          state <= ST_S2;
        end
        ST_S2: begin
          q2    <= diff;
          state <= ST_S3;
        end
        ST_S3: begin
          q3    <= diff;
          done  <= 1'b1;
          state <= ST_FIN;
        end
        ST_FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_column_message_extractor.sv
// Scoreboard bench for column_message_extractor: stimulus pushes hand-computed
// results, a negedge monitor checks timing, held values and popped results.
module tb_column_message_extractor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] sum = '0, r1 = '0, r2 = '0, r3 = '0;
  logic [31:0] q1, q2, q3;
  logic        busy, done;

  typedef struct packed {
    logic [31:0] q1;
    logic [31:0] q2;
    logic [31:0] q3;
  } exp_t;

  exp_t sb[$];
  exp_t last = '0;
  int   errors = 0;
  int   checks = 0;
  int   phase  = 0;

  column_message_extractor dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sum   (sum),
    .r1    (r1),
    .r2    (r2),
    .r3    (r3),
    .q1    (q1),
    .q2    (q2),
    .q3    (q3),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-position reference: 1..4 for S1..FIN, 0 when idle
  always @(posedge clk or posedge rst) begin
    if (rst)               phase <= 0;
    else if (phase == 0)   phase <= start ? 1 : 0;
    else if (phase == 4)   phase <= 0;
    else                   phase <= phase + 1;
  end

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      last = '0;
      chk("rst_q1", q1, 32'h0);
      chk("rst_q2", q2, 32'h0);
      chk("rst_q3", q3, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_done", {31'b0, done}, 32'h0);
    end else begin
      chk("busy", {31'b0, busy}, {31'b0, phase != 0});
      chk("done", {31'b0, done}, {31'b0, phase == 4});
      if (phase == 1) begin
        chk("hold_q1", q1, last.q1);
        chk("hold_q2", q2, last.q2);
        chk("hold_q3", q3, last.q3);
      end
      if (sb.size() > 0) begin
        if (phase == 2) chk("step_q1", q1, sb[0].q1);
        if (phase == 3) chk("step_q2", q2, sb[0].q2);
        if (phase == 4) chk("step_q3", q3, sb[0].q3);
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'h1, 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("res_q1", q1, e.q1);
          chk("res_q2", q2, e.q2);
          chk("res_q3", q3, e.q3);
          last = e;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Start one operation, push its expectation, then scramble the inputs
  task automatic run_op(input logic [31:0] s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] e1, input logic [31:0] e2,
                        input logic [31:0] e3);
    sum = s; r1 = a; r2 = b; r3 = c; start = 1'b1;
    sb.push_back('{e1, e2, e3});
    tick();
    start = 1'b0;
    sum = 32'h4479_8000; r1 = 32'h4120_0000; r2 = 32'hC120_0000; r3 = 32'h3E80_0000;
    repeat (4) tick();
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();

    run_op(32'h40E00000, 32'h3F800000, 32'h40000000, 32'h40800000,
           32'h40C00000, 32'h40A00000, 32'h40400000);
    run_op(32'h3F800000, 32'h40400000, 32'h3F800000, 32'h3F000000,
           32'hC0000000, 32'h00000000, 32'h3F000000);
    run_op(32'h40000000, 32'h3F800000, 32'h40000000, 32'hC0000000,
           32'h3F800000, 32'h00000000, 32'h40800000);
    // overflow to +inf, denormal operand flushed, truncated max - 1.0
    run_op(32'h7F7FFFFF, 32'hFF7FFFFF, 32'h00400000, 32'h3F800000,
           32'h7F800000, 32'h7F7FFFFF, 32'h7F7FFFFE);

    // start pulse with new operands during S2 must be ignored
    sum = 32'h40E00000; r1 = 32'hBF800000; r2 = 32'h40E00000; r3 = 32'h3F000000; start = 1'b1;
    sb.push_back('{32'h41000000, 32'h00000000, 32'h40D00000});
    tick();
    start = 1'b0;
    tick();
    sum = 32'h3F800000; r1 = 32'h3F800000; r2 = 32'h3F800000; r3 = 32'h3F800000; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();

    // reset during S2 aborts the operation
    sum = 32'h41200000; r1 = 32'h3F800000; r2 = 32'h3F800000; r3 = 32'h3F800000; start = 1'b1;
    sb.push_back('{32'h41100000, 32'h41100000, 32'h41100000});
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    run_op(32'h40E00000, 32'h3F800000, 32'h40000000, 32'h40800000,
           32'h40C00000, 32'h40A00000, 32'h40400000);

    // start held high: second op latches operands present at its accepting edge
    sum = 32'h41200000; r1 = 32'h40A00000; r2 = 32'h41200000; r3 = 32'h3F800000; start = 1'b1;
    sb.push_back('{32'h40A00000, 32'h00000000, 32'h41100000});
    tick();
    sum = 32'h42C80000; r1 = 32'h42C80000; r2 = 32'h3F800000; r3 = 32'hC2C80000;
    sb.push_back('{32'h00000000, 32'h42C60000, 32'h43480000});
    repeat (5) tick();
    start = 1'b0;
    repeat (6) tick();

    chk("queue_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
